// File: rtl/va_sep_alloc.sv
// Separable input-first VC allocator with output-VC ownership tracking.
// Stage 1: every input VC round-robin picks one free requested output VC.
// Stage 2: every output VC round-robin picks one input VC among those that chose it.
// Grants are registered; an output VC stays owned until its tail-flit release.
module va_sep_alloc #(
    parameter int NP = 5,
    parameter int NV = 4,
    parameter int IW = $clog2(NP*NV)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NP*NV*NP*NV-1:0]      in_req,
    input  logic [NP*NV-1:0]            out_release,
    output logic [NP*NV-1:0]            in_gnt,
    output logic [NP*NV*IW-1:0]         in_gnt_ovc,
    output logic [NP*NV-1:0]            ovc_busy,
    output logic                        rel_err
);
    localparam int T = NP*NV;

    // Pointer increment wraps at T, not at 2^IW.
    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] x);
        return (int'(x) == T-1) ? '0 : x + IW'(1);
    endfunction

    // Round-robin pick: {valid, index}. Scans from highest to lowest priority
    // so the last hit written is the one closest to ptr.
    function automatic logic [IW:0] f_rr(input logic [T-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = T-1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= T) idx = idx - T;
            if (req[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    logic [T-1:0][T-1:0]  w_req;
    logic [T-1:0]         w_s1_vld;
    logic [T-1:0][IW-1:0] w_s1_sel;
    logic [T-1:0][T-1:0]  w_cand;     // [output j][input i]
    logic [T-1:0]         w_s2_vld;
    logic [T-1:0][IW-1:0] w_s2_sel;
    logic [T-1:0]         w_won;

    logic [T-1:0]         r_busy;
    logic [T-1:0]         r_gnt;
    logic [T-1:0][IW-1:0] r_gnt_ovc;
    logic [T-1:0][IW-1:0] r_ip;
    logic [T-1:0][IW-1:0] r_op;
    logic                 r_rel_err;

    assign w_req = in_req;

    genvar gi, gj;
    generate
        for (gi = 0; gi < T; gi++) begin : g_in
            // Stage 1: masked by the registered busy vector only.
            assign {w_s1_vld[gi], w_s1_sel[gi]} = f_rr(w_req[gi] & ~r_busy, r_ip[gi]);
            // Input wins if the output it picked picked it back.
            assign w_won[gi] = w_s1_vld[gi] && w_s2_vld[w_s1_sel[gi]] &&
                               (w_s2_sel[w_s1_sel[gi]] == IW'(gi));
        end
        for (gj = 0; gj < T; gj++) begin : g_out
            for (gi = 0; gi < T; gi++) begin : g_cand
                assign w_cand[gj][gi] = w_s1_vld[gi] && (w_s1_sel[gi] == IW'(gj));
            end
            // Stage 2: one input per output VC.
            assign {w_s2_vld[gj], w_s2_sel[gj]} = f_rr(w_cand[gj], r_op[gj]);
        end
    endgenerate

    // Ownership and error flag: a release of an idle VC changes nothing but flags rel_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy    <= '0;
            r_rel_err <= 1'b0;
        end else begin
            r_busy    <= (r_busy & ~out_release) | w_s2_vld;
            r_rel_err <= |(out_release & ~r_busy);
        end
    end

    // Registered grant pulse and granted index per input VC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gnt     <= '0;
            r_gnt_ovc <= '0;
        end else begin
            r_gnt <= w_won;
            for (int i = 0; i < T; i++)
                r_gnt_ovc[i] <= w_won[i] ? w_s1_sel[i] : '0;
        end
    end

    // Round-robin pointers move only on a final grant; stage-2 losers keep theirs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ip <= '0;
            r_op <= '0;
        end else begin
            for (int i = 0; i < T; i++)
                if (w_won[i]) r_ip[i] <= f_inc(w_s1_sel[i]);
            for (int j = 0; j < T; j++)
                if (w_s2_vld[j]) r_op[j] <= f_inc(w_s2_sel[j]);
        end
    end

    assign in_gnt     = r_gnt;
    assign in_gnt_ovc = r_gnt_ovc;
    assign ovc_busy   = r_busy;
    assign rel_err    = r_rel_err;
endmodule

// File: tb/tb_va_sep_alloc.sv
// Self-checking bench for va_sep_alloc (NP=5, NV=4): directed scenarios scored
// through an expectation queue, plus a full-load matching check.
module tb_va_sep_alloc;
    localparam int NP = 5;
    localparam int NV = 4;
    localparam int T  = NP*NV;
    localparam int IW = $clog2(T);

    logic                 clk  = 1'b0;
    logic                 rstn = 1'b0;
    logic [T-1:0][T-1:0]  rq   = '0;
    logic [T-1:0]         rel  = '0;
    logic [T-1:0]         in_gnt;
    logic [T*IW-1:0]      in_gnt_ovc;
    logic [T-1:0]         ovc_busy;
    logic                 rel_err;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int           gi;     // expected granted input, -1 for none
        int           go;     // expected output VC index for gi
        logic [T-1:0] busy;
        logic         err;
        bit           exact;
    } exp_t;
    exp_t sbq[$];

    va_sep_alloc #(.NP(NP), .NV(NV)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_req      (rq),
        .out_release (rel),
        .in_gnt      (in_gnt),
        .in_gnt_ovc  (in_gnt_ovc),
        .ovc_busy    (ovc_busy),
        .rel_err     (rel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    function automatic logic [T-1:0] oh(input int j);
        logic [T-1:0] v;
        v = '0;
        v[j] = 1'b1;
        return v;
    endfunction

    // Inputs are already driven; queue the expectation, take one edge, score.
    task automatic step(input string tag, input int gi, input int go,
                        input logic [T-1:0] eb, input logic ee, input bit exact);
        exp_t e;
        e.gi = gi; e.go = go; e.busy = eb; e.err = ee; e.exact = exact;
        sbq.push_back(e);
        @(posedge clk); #1;
        e = sbq.pop_front();
        if (e.exact) begin
            chk({tag, ".gnt"}, in_gnt, (e.gi >= 0) ? oh(e.gi) : '0);
            if (e.gi >= 0) chk({tag, ".ovc"}, in_gnt_ovc[e.gi*IW +: IW], e.go);
            chk({tag, ".busy"}, ovc_busy, e.busy);
            chk({tag, ".err"}, rel_err, e.err);
        end
    endtask

    // Every input requests every VC; a granted input drops its request.
    task automatic full_load();
        logic [T-1:0] owned, pend, seen;
        int ngr, o;
        owned = '0; pend = '1; ngr = 0;
        rq = '1;
        for (int c = 0; c < 40 && pend != '0; c++) begin
            step("full", -1, 0, '0, 1'b0, 1'b0);
            seen = '0;
            chk("full.prog", |in_gnt, 1);
            for (int i = 0; i < T; i++) begin
                if (in_gnt[i]) begin
                    o = int'(in_gnt_ovc[i*IW +: IW]);
                    chk("full.req", pend[i], 1);
                    chk("full.range", o < T, 1);
                    if (o < T) begin
                        chk("full.dup", owned[o] | seen[o], 0);
                        seen[o] = 1'b1;
                    end
                    pend[i] = 1'b0;
                    rq[i]   = '0;
                    ngr++;
                end
            end
            owned = owned | seen;
            chk("full.busy", ovc_busy, owned);
        end
        chk("full.cnt", ngr, T);
    endtask

    initial begin
        int order[4];
        order[0] = 1; order[1] = 4; order[2] = 9; order[3] = 1;

        // reset state
        #12;
        chk("rst.gnt", in_gnt, 0);
        chk("rst.ovc", in_gnt_ovc, 0);
        chk("rst.busy", ovc_busy, 0);
        chk("rst.err", rel_err, 0);
        @(negedge clk) rstn = 1'b1;
        step("idle", -1, 0, '0, 1'b0, 1'b1);

        // single request
        rq[0][5] = 1'b1;
        step("single", 0, 5, oh(5), 1'b0, 1'b1);
        rq = '0;
        step("single.hold", -1, 0, oh(5), 1'b0, 1'b1);

        // non-one-hot request, pointer moves past the first grant
        rq[3][2] = 1'b1; rq[3][7] = 1'b1;
        step("nonoh1", 3, 2, oh(5) | oh(2), 1'b0, 1'b1);
        rq = '0; rel = oh(2);
        step("rel2", -1, 0, oh(5), 1'b0, 1'b1);
        rel = '0; rq[3][2] = 1'b1; rq[3][7] = 1'b1;
        step("nonoh2", 3, 7, oh(5) | oh(7), 1'b0, 1'b1);
        rq = '0; rel = oh(5) | oh(7);
        step("multirel", -1, 0, '0, 1'b0, 1'b1);
        rel = '0;

        // contention on VC6, rotating fairness
        rq[1][6] = 1'b1; rq[4][6] = 1'b1; rq[9][6] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step("cont", order[k], 6, oh(6), 1'b0, 1'b1);
            rel = oh(6);
            step("cont.rel", -1, 0, '0, 1'b0, 1'b1);
            rel = '0;
        end
        rq = '0;

        // busy masking, then grant one cycle after release
        rq[1][6] = 1'b1;
        step("own6", 1, 6, oh(6), 1'b0, 1'b1);
        rq = '0; rq[2][6] = 1'b1;
        step("mask", -1, 0, oh(6), 1'b0, 1'b1);
        step("mask2", -1, 0, oh(6), 1'b0, 1'b1);
        rel = oh(6);
        step("mask.rel", -1, 0, '0, 1'b0, 1'b1);
        rel = '0;
        step("mask.gnt", 2, 6, oh(6), 1'b0, 1'b1);
        rq = '0; rel = oh(6);
        step("mask.free", -1, 0, '0, 1'b0, 1'b1);
        rel = '0;

        // release of an idle VC
        rq[5][3] = 1'b1;
        step("own3", 5, 3, oh(3), 1'b0, 1'b1);
        rq = '0; rel = oh(10);
        step("badrel", -1, 0, oh(3), 1'b1, 1'b1);
        rel = '0;
        step("badrel.clr", -1, 0, oh(3), 1'b0, 1'b1);
        rel = oh(3);
        step("rel3", -1, 0, '0, 1'b0, 1'b1);
        rel = '0;

        // top index and pointer wrap
        rq[0][19] = 1'b1;
        step("wrap", 0, 19, oh(19), 1'b0, 1'b1);
        rq = '0; rel = oh(19);
        step("wrap.rel", -1, 0, '0, 1'b0, 1'b1);
        rel = '0; rq[0][0] = 1'b1; rq[0][1] = 1'b1;
        step("wrap2", 0, 0, oh(0), 1'b0, 1'b1);
        rq = '0; rel = oh(0);
        step("wrap2.rel", -1, 0, '0, 1'b0, 1'b1);
        rel = '0;

        full_load();

        // asynchronous reset mid-traffic
        rq = '1;
        #2 rstn = 1'b0;
        #1;
        chk("rst2.gnt", in_gnt, 0);
        chk("rst2.ovc", in_gnt_ovc, 0);
        chk("rst2.busy", ovc_busy, 0);
        chk("rst2.err", rel_err, 0);
        rq = '0;
        @(negedge clk) rstn = 1'b1;
        rq[3][2] = 1'b1; rq[3][9] = 1'b1;
        step("rst.ptr", 3, 2, oh(2), 1'b0, 1'b1);
        rq = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
